// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-request and memory-response signals around the port arbiter.
// Pure wiring: no state, no added latency.
// Flow control is valid/ready on every channel; ownership is fixed by the modports.
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic        inst_req_valid;
  logic [31:0] inst_addr;
  logic        inst_req_ready;
  logic        inst_resp_valid;
  logic [31:0] inst_rdata;
  logic        inst_resp_ready;

  // data requester
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ready;
  logic        data_resp_valid;
  logic [31:0] data_rdata;
  logic        data_resp_ready;

  // memory side
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_ready;

  // arbiter view
  modport master (
    input  inst_req_valid, inst_addr, inst_resp_ready,
    output inst_req_ready, inst_resp_valid, inst_rdata,
    input  data_read, data_write, data_addr, data_wdata, data_wstrb, data_resp_ready,
    output data_req_ready, data_resp_valid, data_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // requesters-plus-memory view
  modport slave (
    output inst_req_valid, inst_addr, inst_resp_ready,
    input  inst_req_ready, inst_resp_valid, inst_rdata,
    output data_read, data_write, data_addr, data_wdata, data_wstrb, data_resp_ready,
    input  data_req_ready, data_resp_valid, data_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages; tag FIFO routes read responses in order.
// Latency: 0 cycles request->memory and response->requester; only arbitration state is registered.
// Backpressure: selection locks until mem_req_ready; reads stall when the tag FIFO is full.
module mem_port_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.master bus
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  // arbitration state
  logic          lock_valid;
  src_e          lock_src;
  logic [SW-1:0] starve_cnt;

  // tag FIFO: one bit per in-flight read, extra pointer bit tells full from empty
  logic [OUTSTANDING-1:0] tag_mem;
  logic [PW:0]            wr_ptr;
  logic [PW:0]            rd_ptr;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   head;

  src_e sel;
  logic req_vld;
  logic accept;
  logic push;
  logic pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = tag_mem[rd_ptr[PW-1:0]];

  // Pick the source: a pending lock wins, then starvation relief, then data, then fetch.
  always_comb begin
    sel = SRC_INST;
    if (lock_valid) begin
      sel = lock_src;
    end else if ((starve_cnt == STARVE_MAX) && bus.inst_req_valid) begin
      sel = SRC_INST;
    end else if (bus.data_read || bus.data_write) begin
      sel = SRC_DATA;
    end else begin
      sel = SRC_INST;
    end
  end

  // Present the selected request; reads are withheld while the registered FIFO state is full,
  // so mem_read/mem_write never depend on mem_req_ready.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = bus.inst_addr;
    bus.mem_wdata = bus.data_wdata;
    bus.mem_wstrb = 4'h0;
    if (sel == SRC_DATA) begin
      bus.mem_read  = bus.data_read && !fifo_full;
      bus.mem_write = bus.data_write;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wstrb = bus.data_wstrb;
    end else begin
      bus.mem_read  = bus.inst_req_valid && !fifo_full;
    end
  end

  assign req_vld            = bus.mem_read || bus.mem_write;
  assign accept             = req_vld && bus.mem_req_ready;
  assign push               = bus.mem_read && bus.mem_req_ready;
  assign bus.inst_req_ready = accept && (sel == SRC_INST);
  assign bus.data_req_ready = accept && (sel == SRC_DATA);

  // Response routing follows the FIFO head; both data buses simply mirror memory.
  assign bus.inst_resp_valid = bus.mem_resp_valid && !fifo_empty && !head;
  assign bus.data_resp_valid = bus.mem_resp_valid && !fifo_empty && head;
  assign bus.mem_resp_ready  = !fifo_empty && (head ? bus.data_resp_ready : bus.inst_resp_ready);
  assign bus.inst_rdata      = bus.mem_rdata;
  assign bus.data_rdata      = bus.mem_rdata;
  assign pop                 = bus.mem_resp_valid && bus.mem_resp_ready;

  // Lock holds a presented-but-stalled selection; starvation counter tracks data wins over a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_src   <= SRC_INST;
      starve_cnt <= '0;
    end else begin
      if (req_vld && !bus.mem_req_ready) begin
        lock_valid <= 1'b1;
        lock_src   <= sel;
      end else if (accept) begin
        lock_valid <= 1'b0;
      end

      if (!bus.inst_req_valid) begin
        starve_cnt <= '0;
      end else if (accept && (sel == SRC_INST)) begin
        starve_cnt <= '0;
      end else if (accept && (sel == SRC_DATA) && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Tag FIFO pointers: push the source of each accepted read, pop on each consumed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr[PW-1:0]] <= (sel == SRC_DATA);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority, lock, starvation, full FIFO, backpressure, reset.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// The bench plays both requesters and the memory, with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .OUTSTANDING (4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    bus.inst_req_valid  = 1'b0;
    bus.inst_addr       = 32'h0;
    bus.inst_resp_ready = 1'b0;
    bus.data_read       = 1'b0;
    bus.data_write      = 1'b0;
    bus.data_addr       = 32'h0;
    bus.data_wdata      = 32'h0;
    bus.data_wstrb      = 4'h0;
    bus.data_resp_ready = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_resp_valid  = 1'b0;
    bus.mem_rdata       = 32'h0;
  endtask

  // Return n responses, one per cycle, then confirm the FIFO reads as empty.
  task automatic drain(input int n);
    bus.mem_resp_valid  = 1'b1;
    bus.inst_resp_ready = 1'b1;
    bus.data_resp_ready = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    check("drain_empty", {31'h0, bus.mem_resp_ready}, 32'h0);
    bus.mem_resp_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- reset state: empty FIFO blocks responses even with valid/ready high
    bus.mem_resp_valid  = 1'b1;
    bus.inst_resp_ready = 1'b1;
    bus.data_resp_ready = 1'b1;
    #1;
    check("rst_mem_read",   {31'h0, bus.mem_read},        32'h0);
    check("rst_mem_write",  {31'h0, bus.mem_write},       32'h0);
    check("rst_resp_ready", {31'h0, bus.mem_resp_ready},  32'h0);
    check("rst_inst_rv",    {31'h0, bus.inst_resp_valid}, 32'h0);
    check("rst_data_rv",    {31'h0, bus.data_resp_valid}, 32'h0);
    check("rst_starve",     32'(dut.starve_cnt),          32'h0);
    check("rst_lock",       {31'h0, dut.lock_valid},      32'h0);
    idle();

    // ---- data priority, then in-order response routing
    @(negedge clk);
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0100;
    bus.data_read      = 1'b1; bus.data_addr = 32'h0000_0200;
    bus.mem_req_ready  = 1'b1;
    #1;
    check("pri_addr0", bus.mem_addr, 32'h0000_0200);
    check("pri_dgnt0", {31'h0, bus.data_req_ready}, 32'h1);
    check("pri_ignt0", {31'h0, bus.inst_req_ready}, 32'h0);
    @(negedge clk);
    bus.data_read = 1'b0;
    #1;
    check("pri_addr1", bus.mem_addr, 32'h0000_0100);
    check("pri_ignt1", {31'h0, bus.inst_req_ready}, 32'h1);
    @(negedge clk);
    bus.inst_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hAAAA_0000;
    bus.inst_resp_ready = 1'b1; bus.data_resp_ready = 1'b1;
    #1;
    check("r0_data_rv", {31'h0, bus.data_resp_valid}, 32'h1);
    check("r0_inst_rv", {31'h0, bus.inst_resp_valid}, 32'h0);
    check("r0_rdata",   bus.data_rdata, 32'hAAAA_0000);
    @(negedge clk);
    bus.mem_rdata = 32'hBBBB_1111;
    #1;
    check("r1_inst_rv", {31'h0, bus.inst_resp_valid}, 32'h1);
    check("r1_data_rv", {31'h0, bus.data_resp_valid}, 32'h0);
    check("r1_rdata",   bus.inst_rdata, 32'hBBBB_1111);
    @(negedge clk);
    #1;
    check("r2_empty_rdy", {31'h0, bus.mem_resp_ready},  32'h0);
    check("r2_empty_iv",  {31'h0, bus.inst_resp_valid}, 32'h0);
    idle();

    // ---- lock: stalled fetch keeps the port although data arrives
    @(negedge clk);
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0300;
    #1;
    check("lk_read0", {31'h0, bus.mem_read}, 32'h1);
    check("lk_addr0", bus.mem_addr, 32'h0000_0300);
    @(negedge clk);
    bus.data_read = 1'b1; bus.data_addr = 32'h0000_0400;
    #1;
    check("lk_addr1", bus.mem_addr, 32'h0000_0300);
    @(negedge clk);
    #1;
    check("lk_addr2", bus.mem_addr, 32'h0000_0300);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    check("lk_addr3", bus.mem_addr, 32'h0000_0300);
    check("lk_ignt3", {31'h0, bus.inst_req_ready}, 32'h1);
    check("lk_dgnt3", {31'h0, bus.data_req_ready}, 32'h0);
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
    #1;
    check("lk_addr4", bus.mem_addr, 32'h0000_0400);
    check("lk_dgnt4", {31'h0, bus.data_req_ready}, 32'h1);
    @(negedge clk);
    bus.data_read = 1'b0; bus.mem_req_ready = 1'b0;
    drain(2);
    idle();

    // ---- starvation: four data wins, then fetch is forced through
    @(negedge clk);
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0500;
    bus.data_read      = 1'b1; bus.data_addr = 32'h0000_0504;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.inst_resp_ready = 1'b1; bus.data_resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("sv_cnt%0d", k),  32'(dut.starve_cnt), 32'(k));
      check($sformatf("sv_dgnt%0d", k), {31'h0, bus.data_req_ready}, (k < 4) ? 32'h1 : 32'h0);
      check($sformatf("sv_ignt%0d", k), {31'h0, bus.inst_req_ready}, (k == 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    #1;
    check("sv_cnt_clr", 32'(dut.starve_cnt), 32'h0);
    check("sv_dgnt5",   {31'h0, bus.data_req_ready}, 32'h1);
    bus.inst_req_valid = 1'b0; bus.data_read = 1'b0; bus.mem_req_ready = 1'b0;
    drain(1);
    idle();

    // ---- full FIFO: fifth read held, write still passes, pop frees space next cycle
    @(negedge clk);
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0600;
    bus.mem_req_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("ff_ignt%0d", k), {31'h0, bus.inst_req_ready}, 32'h1);
    end
    @(negedge clk);
    bus.data_write = 1'b1; bus.data_addr = 32'h0000_0700;
    bus.data_wdata = 32'hDEAD_BEEF; bus.data_wstrb = 4'hF;
    #1;
    check("ff_read_blk", {31'h0, bus.mem_read},       32'h0);
    check("ff_write",    {31'h0, bus.mem_write},      32'h1);
    check("ff_wgnt",     {31'h0, bus.data_req_ready}, 32'h1);
    check("ff_ignt4",    {31'h0, bus.inst_req_ready}, 32'h0);
    check("ff_wdata",    bus.mem_wdata, 32'hDEAD_BEEF);
    check("ff_wstrb",    {28'h0, bus.mem_wstrb}, 32'hF);
    check("ff_waddr",    bus.mem_addr, 32'h0000_0700);
    @(negedge clk);
    bus.data_write = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.inst_resp_ready = 1'b1;
    #1;
    check("ff_read_pop", {31'h0, bus.mem_read},        32'h0);
    check("ff_pop_iv",   {31'h0, bus.inst_resp_valid}, 32'h1);
    check("ff_pop_rdy",  {31'h0, bus.mem_resp_ready},  32'h1);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    check("ff_read_go", {31'h0, bus.mem_read},       32'h1);
    check("ff_ignt5",   {31'h0, bus.inst_req_ready}, 32'h1);
    @(negedge clk);
    bus.inst_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
    drain(4);
    idle();

    // ---- response backpressure
    @(negedge clk);
    bus.data_read = 1'b1; bus.data_addr = 32'h0000_0800;
    bus.mem_req_ready = 1'b1;
    #1;
    check("bp_dgnt", {31'h0, bus.data_req_ready}, 32'h1);
    @(negedge clk);
    bus.data_read = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    bus.data_resp_ready = 1'b0; bus.inst_resp_ready = 1'b1;
    #1;
    check("bp_rdy0", {31'h0, bus.mem_resp_ready},  32'h0);
    check("bp_dv0",  {31'h0, bus.data_resp_valid}, 32'h1);
    @(negedge clk);
    #1;
    check("bp_dv1",  {31'h0, bus.data_resp_valid}, 32'h1);
    bus.data_resp_ready = 1'b1;
    #1;
    check("bp_rdy1", {31'h0, bus.mem_resp_ready},  32'h1);
    @(negedge clk);
    #1;
    check("bp_rdy2", {31'h0, bus.mem_resp_ready},  32'h0);
    check("bp_dv2",  {31'h0, bus.data_resp_valid}, 32'h0);
    idle();

    // ---- reset with two reads outstanding
    @(negedge clk);
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0900;
    bus.mem_req_ready  = 1'b1;
    #1;
    check("rm_ignt0", {31'h0, bus.inst_req_ready}, 32'h1);
    @(negedge clk);
    #1;
    check("rm_ignt1", {31'h0, bus.inst_req_ready}, 32'h1);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.inst_resp_ready = 1'b1; bus.data_resp_ready = 1'b1;
    #1;
    check("rm_rdy",  {31'h0, bus.mem_resp_ready},  32'h0);
    check("rm_iv",   {31'h0, bus.inst_resp_valid}, 32'h0);
    bus.mem_resp_valid = 1'b0;
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0A00;
    bus.mem_req_ready  = 1'b1;
    #1;
    check("rm_new_rd",   {31'h0, bus.mem_read},       32'h1);
    check("rm_new_ignt", {31'h0, bus.inst_req_ready}, 32'h1);
    @(negedge clk);
    bus.inst_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    #1;
    check("rm_new_iv", {31'h0, bus.inst_resp_valid}, 32'h1);
    @(negedge clk);
    #1;
    check("rm_after", {31'h0, bus.mem_resp_ready}, 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
